ex_alu_issue: RTL and testbench
===============================

// Module: ex_alu_issue
// PURPOSE
// Issue side of the ALU reservation slot: accepts one decoded instruction, reads regfile/status table,
// fills the single ALU slot (op, pc, tags, data, target) and drives the ALU's busy/tag/data inputs.
// Snoops the writeback bus to wake pending operands; frees the slot when the ALU fires. Sits between decode and ex_alu.
// PARAMETERS
// TAG_W     3  width of producer tag (`regtag_t)
// UNLOCKED  0  tag value meaning "operand/register ready"
// ALU_TAG   1  producer tag owned by the ALU; written into status[rd] on issue
// OP_W      6  width of op code (`sinst_t)
// PORTS
// clk          in   1      clock, all state on posedge
// rst          in   1      synchronous, active-high reset
// dec_valid_in in   1      decode offers instruction
// dec_ready_out out 1      issue accepts this cycle (comb.)
// dec_op_in    in   OP_W   op
// dec_pc_in    in   32     instruction pc
// dec_rs1_in/dec_rs2_in/dec_rd_in in 5 each  register addresses
// dec_rs1_en_in/dec_rs2_en_in/dec_imm_en_in in 1 each  operand-source flags
// dec_imm_in   in   32     sign-extended immediate
// dec_is_jmp_in in  1      JAL/JALR
// rf_addr_x_out/rf_addr_y_out out 5   comb. regfile read addresses (= dec_rs1_in/dec_rs2_in)
// rf_data_x_in/rf_data_y_in   in  32  comb. regfile read data
// wb_en_in     in   1      writeback broadcast valid
// wb_tag_in    in   TAG_W  producer tag of broadcast
// wb_data_in   in   32     broadcast data
// alu_fire_in  in   1      ALU consumed slot this cycle (ex_alu en)
// jmp_in       in   1      ALU jump resolved (ex_alu en_jmp, registered)
// alu_busy_out out  1      slot occupied
// alu_op_out   out  OP_W;  alu_pc_out out 32
// alu_tagx_out/alu_tagy_out/alu_tagw_out out TAG_W  pending producer tags
// alu_datax_out/alu_datay_out out 32;  alu_target_out out 5
// BEHAVIOUR
// - Reset: slot EMPTY; all alu_*_out 0 except tags=UNLOCKED; status[0..31]=UNLOCKED; jmp_pend=0.
// - Slot states: EMPTY -> (issue) WAIT if any tag locked, else READY; WAIT -> READY when last tag unlocks;
//   READY -> EMPTY on alu_fire_in. All outputs registered; slot contents change only on posedge.
// - dec_ready_out = !rst && slot EMPTY && !jmp_pend. Handshake: issue when dec_valid_in && dec_ready_out.
// - Source lookup (x from rs1, y from rs2): reg 0 or status==UNLOCKED -> tag UNLOCKED, data from regfile;
//   status==wb_tag_in with wb_en_in same cycle -> tag UNLOCKED, data=wb_data_in (bypass); else tag=status, data 0.
// - Operand map: datax = rs1_en ? rs1 : imm; datay = rs2_en ? rs2 : (rs1_en&&imm_en ? imm : 0); unused tag UNLOCKED.
// - tagw = status[rd] before issue (WAW), with same bypass rule; rd==0 -> tagw UNLOCKED.
// - Issue with rd!=0: status[rd] <= ALU_TAG (takes priority over a same-cycle wb clear of rd).
// - Wakeup each cycle: wb_en_in && slot tag==wb_tag_in && tag!=UNLOCKED -> tag<=UNLOCKED; x/y also latch wb_data_in.
// - Status clear: wb_en_in -> every status[r]==wb_tag_in becomes UNLOCKED (except rd being issued this cycle).
// - Fire: alu_fire_in while slot occupied -> EMPTY next cycle; no issue in the fire cycle (1 bubble).
//   alu_fire_in while EMPTY ignored.
// - Jump: issuing dec_is_jmp_in sets jmp_pend; issue blocked until jmp_in, which clears jmp_pend next cycle. No flush needed.
// - jmp_in and wb_en_in simultaneous: both take effect. rst mid-operation drops slot and status.
// - Latency: dec handshake -> alu_busy_out=1 next cycle; READY slot -> ALU fires same cycle.
// TESTING
// 1) Reset, issue ADD x3=x1+x2 (all unlocked, rf 5/7) -> next cycle busy=1, tags 0, datax=5, datay=7, target=3; status[3]=1.
// 2) Issue with status[1]=2, then wb_en tag=2 data=0x10 -> tagx 2 then UNLOCKED, datax=0x10 one cycle later.
// 3) wb tag=2 in same cycle as issue reading status[1]=2 -> tagx UNLOCKED, datax=wb_data (bypass).
// 4) JAL issued -> dec_ready_out=0 after fire until jmp_in pulse; ready=1 the cycle after jmp_in.
// 5) rd=0 ADDI -> tagw UNLOCKED, status[0] stays UNLOCKED; alu_fire while EMPTY -> no state change.
// 6) rst asserted while slot WAIT -> busy=0, all status UNLOCKED next cycle.

Source files
------------

// File: rtl/ex_alu_issue.sv
// Issue stage for the single ALU reservation slot: captures a decoded instruction,
// resolves operands against the register status table and wakes them from the writeback bus.
module ex_alu_issue #(
    parameter int TAG_W = 3,
    parameter logic [TAG_W-1:0] UNLOCKED = TAG_W'(0),
    parameter logic [TAG_W-1:0] ALU_TAG = TAG_W'(1),
    parameter int OP_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid_in,
    output logic             dec_ready_out,
    input  logic [OP_W-1:0]  dec_op_in,
    input  logic [31:0]      dec_pc_in,
    input  logic [4:0]       dec_rs1_in,
    input  logic [4:0]       dec_rs2_in,
    input  logic [4:0]       dec_rd_in,
    input  logic             dec_rs1_en_in,
    input  logic             dec_rs2_en_in,
    input  logic             dec_imm_en_in,
    input  logic [31:0]      dec_imm_in,
    input  logic             dec_is_jmp_in,
    output logic [4:0]       rf_addr_x_out,
    output logic [4:0]       rf_addr_y_out,
    input  logic [31:0]      rf_data_x_in,
    input  logic [31:0]      rf_data_y_in,
    input  logic             wb_en_in,
    input  logic [TAG_W-1:0] wb_tag_in,
    input  logic [31:0]      wb_data_in,
    input  logic             alu_fire_in,
    input  logic             jmp_in,
    output logic             alu_busy_out,
    output logic [OP_W-1:0]  alu_op_out,
    output logic [31:0]      alu_pc_out,
    output logic [TAG_W-1:0] alu_tagx_out,
    output logic [TAG_W-1:0] alu_tagy_out,
    output logic [TAG_W-1:0] alu_tagw_out,
    output logic [31:0]      alu_datax_out,
    output logic [31:0]      alu_datay_out,
    output logic [4:0]       alu_target_out
);

    typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} slot_state_t;

    slot_state_t      r_state, w_state_nxt;
    logic [TAG_W-1:0] r_status [32];
    logic             r_jmp_pend;

    logic [OP_W-1:0]  r_op;
    logic [31:0]      r_pc;
    logic [TAG_W-1:0] r_tagx, r_tagy, r_tagw;
    logic [31:0]      r_datax, r_datay;
    logic [4:0]       r_target;

    logic             w_issue;
    logic [TAG_W+31:0] w_look_x, w_look_y;
    logic [TAG_W-1:0] w_iss_tagx, w_iss_tagy, w_iss_tagw;
    logic [31:0]      w_iss_datax, w_iss_datay;
    logic [TAG_W-1:0] w_st_rd;
    logic             w_wake_x, w_wake_y, w_wake_w;
    logic [TAG_W-1:0] w_tagx_nxt, w_tagy_nxt, w_tagw_nxt;

    // Register 0 and unlocked registers read the regfile; a same-cycle broadcast bypasses.
    function automatic logic [TAG_W+31:0] f_lookup(
        input logic             a_zero,
        input logic [TAG_W-1:0] a_st,
        input logic [31:0]      a_rf,
        input logic             a_wben,
        input logic [TAG_W-1:0] a_wbtag,
        input logic [31:0]      a_wbdata
    );
        if (a_zero || a_st == UNLOCKED)
            return {UNLOCKED, a_rf};
        else if (a_wben && a_st == a_wbtag)
            return {UNLOCKED, a_wbdata};
        else
            return {a_st, 32'd0};
    endfunction

    assign dec_ready_out = !rst && (r_state == S_EMPTY) && !r_jmp_pend;
    assign w_issue       = dec_valid_in && dec_ready_out;
    assign rf_addr_x_out = dec_rs1_in;
    assign rf_addr_y_out = dec_rs2_in;

    assign w_look_x = f_lookup(dec_rs1_in == 5'd0, r_status[dec_rs1_in], rf_data_x_in,
                               wb_en_in, wb_tag_in, wb_data_in);
    assign w_look_y = f_lookup(dec_rs2_in == 5'd0, r_status[dec_rs2_in], rf_data_y_in,
                               wb_en_in, wb_tag_in, wb_data_in);
    assign w_st_rd  = r_status[dec_rd_in];

    always_comb begin
        w_iss_tagx  = UNLOCKED;
        w_iss_tagy  = UNLOCKED;
        w_iss_tagw  = UNLOCKED;
        w_iss_datax = dec_imm_in;
        w_iss_datay = 32'd0;
        if (dec_rs1_en_in) begin
            w_iss_tagx  = w_look_x[TAG_W+31:32];
            w_iss_datax = w_look_x[31:0];
        end
        if (dec_rs2_en_in) begin
            w_iss_tagy  = w_look_y[TAG_W+31:32];
            w_iss_datay = w_look_y[31:0];
        end else if (dec_rs1_en_in && dec_imm_en_in) begin
            w_iss_datay = dec_imm_in;
        end
        if (dec_rd_in != 5'd0 && w_st_rd != UNLOCKED &&
            !(wb_en_in && w_st_rd == wb_tag_in))
            w_iss_tagw = w_st_rd;
    end

    assign w_wake_x   = wb_en_in && r_tagx == wb_tag_in && r_tagx != UNLOCKED;
    assign w_wake_y   = wb_en_in && r_tagy == wb_tag_in && r_tagy != UNLOCKED;
    assign w_wake_w   = wb_en_in && r_tagw == wb_tag_in && r_tagw != UNLOCKED;
    assign w_tagx_nxt = w_wake_x ? UNLOCKED : r_tagx;
    assign w_tagy_nxt = w_wake_y ? UNLOCKED : r_tagy;
    assign w_tagw_nxt = w_wake_w ? UNLOCKED : r_tagw;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_EMPTY;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_issue) begin
                    if (w_iss_tagx != UNLOCKED || w_iss_tagy != UNLOCKED || w_iss_tagw != UNLOCKED)
                        w_state_nxt = S_WAIT;
                    else
                        w_state_nxt = S_READY;
                end
            end
            S_WAIT: begin
                if (alu_fire_in)
                    w_state_nxt = S_EMPTY;
                else if (w_tagx_nxt == UNLOCKED && w_tagy_nxt == UNLOCKED && w_tagw_nxt == UNLOCKED)
                    w_state_nxt = S_READY;
            end
            S_READY: begin
                if (alu_fire_in) w_state_nxt = S_EMPTY;
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_pc     <= '0;
            r_tagx   <= UNLOCKED;
            r_tagy   <= UNLOCKED;
            r_tagw   <= UNLOCKED;
            r_datax  <= '0;
            r_datay  <= '0;
            r_target <= '0;
        end else if (w_issue) begin
            r_op     <= dec_op_in;
            r_pc     <= dec_pc_in;
            r_tagx   <= w_iss_tagx;
            r_tagy   <= w_iss_tagy;
            r_tagw   <= w_iss_tagw;
            r_datax  <= w_iss_datax;
            r_datay  <= w_iss_datay;
            r_target <= dec_rd_in;
        end else begin
            r_tagx <= w_tagx_nxt;
            r_tagy <= w_tagy_nxt;
            r_tagw <= w_tagw_nxt;
            if (w_wake_x) r_datax <= wb_data_in;
            if (w_wake_y) r_datay <= wb_data_in;
        end
    end

    // The issue write to status[rd] is placed last so it wins over a same-cycle broadcast clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) r_status[r] <= UNLOCKED;
        end else begin
            for (int r = 0; r < 32; r++)
                if (wb_en_in && r_status[r] == wb_tag_in) r_status[r] <= UNLOCKED;
            if (w_issue && dec_rd_in != 5'd0) r_status[dec_rd_in] <= ALU_TAG;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                          r_jmp_pend <= 1'b0;
        else if (w_issue && dec_is_jmp_in) r_jmp_pend <= 1'b1;
        else if (jmp_in)                  r_jmp_pend <= 1'b0;
    end

    assign alu_busy_out   = (r_state != S_EMPTY);
    assign alu_op_out     = r_op;
    assign alu_pc_out     = r_pc;
    assign alu_tagx_out   = r_tagx;
    assign alu_tagy_out   = r_tagy;
    assign alu_tagw_out   = r_tagw;
    assign alu_datax_out  = r_datax;
    assign alu_datay_out  = r_datay;
    assign alu_target_out = r_target;

endmodule

// File: tb/tb_ex_alu_issue.sv
// Directed bench for ex_alu_issue: issued slot contents go through a scoreboard queue,
// intermediate tag/ready behaviour is checked with immediate assertions.
module tb_ex_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid_in, dec_ready_out;
    logic [5:0]  dec_op_in;
    logic [31:0] dec_pc_in, dec_imm_in;
    logic [4:0]  dec_rs1_in, dec_rs2_in, dec_rd_in;
    logic        dec_rs1_en_in, dec_rs2_en_in, dec_imm_en_in, dec_is_jmp_in;
    logic [4:0]  rf_addr_x_out, rf_addr_y_out;
    logic [31:0] rf_data_x_in, rf_data_y_in;
    logic        wb_en_in;
    logic [2:0]  wb_tag_in;
    logic [31:0] wb_data_in;
    logic        alu_fire_in, jmp_in, alu_busy_out;
    logic [5:0]  alu_op_out;
    logic [31:0] alu_pc_out, alu_datax_out, alu_datay_out;
    logic [2:0]  alu_tagx_out, alu_tagy_out, alu_tagw_out;
    logic [4:0]  alu_target_out;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] pc;
        logic [31:0] datax;
        logic [31:0] datay;
        logic [4:0]  target;
    } slot_t;

    slot_t sb[$];
    int    nAssert = 0;
    int    nFail   = 0;

    ex_alu_issue dut (
        .clk(clk), .rst(rst),
        .dec_valid_in(dec_valid_in), .dec_ready_out(dec_ready_out),
        .dec_op_in(dec_op_in), .dec_pc_in(dec_pc_in),
        .dec_rs1_in(dec_rs1_in), .dec_rs2_in(dec_rs2_in), .dec_rd_in(dec_rd_in),
        .dec_rs1_en_in(dec_rs1_en_in), .dec_rs2_en_in(dec_rs2_en_in),
        .dec_imm_en_in(dec_imm_en_in), .dec_imm_in(dec_imm_in),
        .dec_is_jmp_in(dec_is_jmp_in),
        .rf_addr_x_out(rf_addr_x_out), .rf_addr_y_out(rf_addr_y_out),
        .rf_data_x_in(rf_data_x_in), .rf_data_y_in(rf_data_y_in),
        .wb_en_in(wb_en_in), .wb_tag_in(wb_tag_in), .wb_data_in(wb_data_in),
        .alu_fire_in(alu_fire_in), .jmp_in(jmp_in),
        .alu_busy_out(alu_busy_out), .alu_op_out(alu_op_out), .alu_pc_out(alu_pc_out),
        .alu_tagx_out(alu_tagx_out), .alu_tagy_out(alu_tagy_out), .alu_tagw_out(alu_tagw_out),
        .alu_datax_out(alu_datax_out), .alu_datay_out(alu_datay_out),
        .alu_target_out(alu_target_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Offers one instruction, checks the handshake and leaves time just after the issue edge.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] pc,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic rs1En, input logic rs2En, input logic immEn,
                                 input logic [31:0] imm, input logic isJmp,
                                 input logic [31:0] rfx, input logic [31:0] rfy,
                                 input logic [31:0] expX, input logic [31:0] expY);
        slot_t e;
        dec_op_in = op; dec_pc_in = pc; dec_rs1_in = rs1; dec_rs2_in = rs2; dec_rd_in = rd;
        dec_rs1_en_in = rs1En; dec_rs2_en_in = rs2En; dec_imm_en_in = immEn;
        dec_imm_in = imm; dec_is_jmp_in = isJmp;
        rf_data_x_in = rfx; rf_data_y_in = rfy;
        dec_valid_in = 1'b1;
        #1;
        checkOutput("issue_ready", {31'd0, dec_ready_out}, 32'd1);
        checkOutput("rf_addr_x", {27'd0, rf_addr_x_out}, {27'd0, rs1});
        e.op = op; e.pc = pc; e.datax = expX; e.datay = expY; e.target = rd;
        sb.push_back(e);
        tick();
        dec_valid_in = 1'b0;
        dec_is_jmp_in = 1'b0;
    endtask

    // Waits (bounded) for a ready slot, then compares it against the oldest scoreboard entry.
    task automatic checkSlot(input string name);
        slot_t e;
        int n = 0;
        while (!(alu_busy_out && alu_tagx_out == 3'd0 && alu_tagy_out == 3'd0 &&
                 alu_tagw_out == 3'd0) && n < 5) begin
            tick();
            n++;
        end
        checkOutput({name, "_ready_wait"}, {31'd0, n < 5}, 32'd1);
        if (sb.size() == 0) begin
            checkOutput({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            checkOutput({name, "_op"}, {26'd0, alu_op_out}, {26'd0, e.op});
            checkOutput({name, "_pc"}, alu_pc_out, e.pc);
            checkOutput({name, "_datax"}, alu_datax_out, e.datax);
            checkOutput({name, "_datay"}, alu_datay_out, e.datay);
            checkOutput({name, "_target"}, {27'd0, alu_target_out}, {27'd0, e.target});
        end
    endtask

    task automatic fireSlot(input string name);
        alu_fire_in = 1'b1;
        #1;
        checkOutput({name, "_no_issue_in_fire"}, {31'd0, dec_ready_out}, 32'd0);
        tick();
        alu_fire_in = 1'b0;
        checkOutput({name, "_busy_after_fire"}, {31'd0, alu_busy_out}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; dec_valid_in = 0; dec_op_in = 0; dec_pc_in = 0; dec_imm_in = 0;
        dec_rs1_in = 0; dec_rs2_in = 0; dec_rd_in = 0; dec_rs1_en_in = 0; dec_rs2_en_in = 0;
        dec_imm_en_in = 0; dec_is_jmp_in = 0; rf_data_x_in = 0; rf_data_y_in = 0;
        wb_en_in = 0; wb_tag_in = 0; wb_data_in = 0; alu_fire_in = 0; jmp_in = 0;
        tick(); tick();
        checkOutput("rst_ready", {31'd0, dec_ready_out}, 32'd0);
        checkOutput("rst_busy", {31'd0, alu_busy_out}, 32'd0);
        checkOutput("rst_tagx", {29'd0, alu_tagx_out}, 32'd0);
        checkOutput("rst_datax", alu_datax_out, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready", {31'd0, dec_ready_out}, 32'd1);

        // ADD x3 = x1 + x2, all operands ready
        applyStimulus(6'h01, 32'h100, 5'd1, 5'd2, 5'd3, 1, 1, 0, 32'd0, 0, 32'd5, 32'd7, 32'd5, 32'd7);
        checkOutput("add_busy_next", {31'd0, alu_busy_out}, 32'd1);
        checkOutput("add_tagw", {29'd0, alu_tagw_out}, 32'd0);
        checkSlot("add");
        fireSlot("add");

        // Reads x3 (locked by the ALU tag), then woken by a broadcast
        applyStimulus(6'h02, 32'h104, 5'd3, 5'd2, 5'd4, 1, 1, 0, 32'd0, 0, 32'hDEAD, 32'd7, 32'h10, 32'd7);
        checkOutput("wake_tagx_locked", {29'd0, alu_tagx_out}, 32'd1);
        checkOutput("wake_datax_zero", alu_datax_out, 32'd0);
        wb_en_in = 1; wb_tag_in = 3'd1; wb_data_in = 32'h10;
        tick();
        wb_en_in = 0;
        checkOutput("wake_tagx_unlocked", {29'd0, alu_tagx_out}, 32'd0);
        checkOutput("wake_datax", alu_datax_out, 32'h10);
        checkSlot("wake");
        fireSlot("wake");

        // Producer for x5, then same-cycle bypass for both source and destination
        applyStimulus(6'h03, 32'h108, 5'd0, 5'd0, 5'd5, 0, 0, 0, 32'h20, 0, 32'd0, 32'd0, 32'h20, 32'd0);
        checkSlot("prod5");
        fireSlot("prod5");
        wb_en_in = 1; wb_tag_in = 3'd1; wb_data_in = 32'h55;
        applyStimulus(6'h04, 32'h10C, 5'd5, 5'd0, 5'd5, 1, 0, 0, 32'd0, 0, 32'hBAD, 32'd0, 32'h55, 32'd0);
        wb_en_in = 0;
        checkOutput("bypass_tagx", {29'd0, alu_tagx_out}, 32'd0);
        checkOutput("bypass_tagw", {29'd0, alu_tagw_out}, 32'd0);
        checkSlot("bypass");
        fireSlot("bypass");

        // status[5] kept the ALU tag despite the same-cycle clear: WAW and RAW lock
        applyStimulus(6'h05, 32'h110, 5'd5, 5'd0, 5'd5, 1, 0, 0, 32'd0, 0, 32'hBAD, 32'd0, 32'h77, 32'd0);
        checkOutput("waw_tagx", {29'd0, alu_tagx_out}, 32'd1);
        checkOutput("waw_tagw", {29'd0, alu_tagw_out}, 32'd1);
        wb_en_in = 1; wb_tag_in = 3'd1; wb_data_in = 32'h77;
        tick();
        wb_en_in = 0;
        checkOutput("waw_tagw_woken", {29'd0, alu_tagw_out}, 32'd0);
        checkSlot("waw");
        fireSlot("waw");

        // JAL blocks issue until jmp_in; broadcast in the same cycle still clears status[1]
        applyStimulus(6'h06, 32'h114, 5'd0, 5'd0, 5'd1, 0, 0, 0, 32'h8, 1, 32'd0, 32'd0, 32'h8, 32'd0);
        checkSlot("jal");
        fireSlot("jal");
        checkOutput("jal_ready_blocked", {31'd0, dec_ready_out}, 32'd0);
        tick();
        checkOutput("jal_ready_still_blocked", {31'd0, dec_ready_out}, 32'd0);
        jmp_in = 1; wb_en_in = 1; wb_tag_in = 3'd1; wb_data_in = 32'h0;
        #1;
        checkOutput("jal_ready_in_jmp_cycle", {31'd0, dec_ready_out}, 32'd0);
        tick();
        jmp_in = 0; wb_en_in = 0;
        checkOutput("jal_ready_after_jmp", {31'd0, dec_ready_out}, 32'd1);

        // ADDI x0 = x1 + 3: x1 unlocked again, rd 0 never locks
        applyStimulus(6'h07, 32'h118, 5'd1, 5'd0, 5'd0, 1, 0, 1, 32'h3, 0, 32'd9, 32'd0, 32'd9, 32'h3);
        checkOutput("rd0_tagw", {29'd0, alu_tagw_out}, 32'd0);
        checkOutput("rd0_tagx", {29'd0, alu_tagx_out}, 32'd0);
        checkSlot("addi_rd0");
        fireSlot("addi_rd0");
        alu_fire_in = 1;
        tick();
        alu_fire_in = 0;
        checkOutput("idle_fire_busy", {31'd0, alu_busy_out}, 32'd0);
        checkOutput("idle_fire_ready", {31'd0, dec_ready_out}, 32'd1);

        // Reset while the slot waits on x7
        applyStimulus(6'h08, 32'h11C, 5'd0, 5'd0, 5'd7, 0, 0, 0, 32'h1, 0, 32'd0, 32'd0, 32'h1, 32'd0);
        checkSlot("prod7");
        fireSlot("prod7");
        applyStimulus(6'h09, 32'h120, 5'd7, 5'd0, 5'd8, 1, 0, 0, 32'd0, 0, 32'd0, 32'd0, 32'd0, 32'd0);
        checkOutput("pre_rst_wait_tagx", {29'd0, alu_tagx_out}, 32'd1);
        rst = 1;
        sb.delete();
        #1;
        checkOutput("rst_mid_ready", {31'd0, dec_ready_out}, 32'd0);
        tick();
        rst = 0;
        checkOutput("rst_mid_busy", {31'd0, alu_busy_out}, 32'd0);
        checkOutput("rst_mid_tagx", {29'd0, alu_tagx_out}, 32'd0);
        applyStimulus(6'h0A, 32'h124, 5'd7, 5'd8, 5'd9, 1, 1, 0, 32'd0, 0, 32'h33, 32'h44, 32'h33, 32'h44);
        checkOutput("post_rst_tagx", {29'd0, alu_tagx_out}, 32'd0);
        checkOutput("post_rst_tagy", {29'd0, alu_tagy_out}, 32'd0);
        checkSlot("post_rst");
        fireSlot("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
